// File: rtl/dmem_resp_pkg.sv
// Shared constants and helpers for the data-side memory responder:
// access sizes, MMIO address map and byte-lane helpers.
package dmem_resp_pkg;

  localparam int unsigned XLEN = 32;

  // One-hot access sizes.
  localparam logic [2:0] SIZE_B = 3'b001;
  localparam logic [2:0] SIZE_H = 3'b010;
  localparam logic [2:0] SIZE_W = 3'b100;

  localparam logic [XLEN-1:0] MTIMECMP_LO = 32'h0200_4000;
  localparam logic [XLEN-1:0] MTIMECMP_HI = 32'h0200_4004;
  localparam logic [XLEN-1:0] MTIME_LO    = 32'h0200_BFF8;
  localparam logic [XLEN-1:0] MTIME_HI    = 32'h0200_BFFC;
  localparam logic [XLEN-1:0] TOHOST_ADR  = 32'h1000_0000;

  typedef enum logic [2:0] {
    TgtNone,
    TgtRam,
    TgtMtimecmp,
    TgtMtime,
    TgtTohost
  } target_e;

  // Byte lanes touched by an access of the given size at the given offset.
  function automatic logic [3:0] size_lanes(input logic [2:0] size, input logic [1:0] off);
    logic [3:0] m;
    unique case (size)
      SIZE_B:  m = 4'b0001;
      SIZE_H:  m = 4'b0011;
      SIZE_W:  m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m << off;
  endfunction

  function automatic logic [XLEN-1:0] size_mask(input logic [2:0] size);
    logic [XLEN-1:0] m;
    unique case (size)
      SIZE_B:  m = 32'h0000_00FF;
      SIZE_H:  m = 32'h0000_FFFF;
      SIZE_W:  m = 32'hFFFF_FFFF;
      default: m = 32'h0000_0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dmem_resp_if.sv
// Load/store request bus between the execute stage (master) and the
// data memory responder (slave).
interface dmem_resp_if;
  import dmem_resp_pkg::*;

  logic            adr_v_i;
  logic [XLEN-1:0] adr_i;
  logic            is_store_i;
  logic [XLEN-1:0] store_data_i;
  logic [2:0]      access_size_i;
  logic [XLEN-1:0] load_data_o;
  logic            access_fault_o;

  modport master (
    output adr_v_i,
    output adr_i,
    output is_store_i,
    output store_data_i,
    output access_size_i,
    input  load_data_o,
    input  access_fault_o
  );

  modport slave (
    input  adr_v_i,
    input  adr_i,
    input  is_store_i,
    input  store_data_i,
    input  access_size_i,
    output load_data_o,
    output access_fault_o
  );

endinterface

// File: rtl/dmem_clint.sv
// CLINT-style machine timer: prescaled 64-bit mtime, writable mtimecmp and
// a registered timer interrupt computed from the next-cycle values.
module dmem_clint #(
  parameter int unsigned TIMER_DIV = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mtime_we,
  input  logic        mtimecmp_we,
  input  logic        hi_sel,
  input  logic [31:0] wdata,
  output logic [63:0] mtime,
  output logic [63:0] mtimecmp,
  output logic        timer_irq_q
);

  localparam int unsigned PresW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;

  logic [PresW-1:0] presc_q, presc_d;
  logic [63:0]      mtime_q, mtime_d, mtime_inc;
  logic [63:0]      mtimecmp_q, mtimecmp_d;
  logic             irq_d;
  logic             tick;

  assign tick      = (presc_q == PresW'(TIMER_DIV - 1));
  assign mtime_inc = mtime_q + {63'b0, tick};

  always_comb begin
    // A half write replaces only that half; the other keeps increment and carry.
    mtime_d = mtime_inc;
    if (mtime_we) begin
      if (hi_sel) mtime_d[63:32] = wdata;
      else        mtime_d[31:0]  = wdata;
    end

    mtimecmp_d = mtimecmp_q;
    if (mtimecmp_we) begin
      if (hi_sel) mtimecmp_d[63:32] = wdata;
      else        mtimecmp_d[31:0]  = wdata;
    end

    presc_d = (mtime_we || tick) ? '0 : presc_q + PresW'(1);
    irq_d   = (mtime_d >= mtimecmp_d);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q     <= '0;
      mtime_q     <= '0;
      mtimecmp_q  <= '1;
      timer_irq_q <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      timer_irq_q <= irq_d;
    end
  end

  assign mtime    = mtime_q;
  assign mtimecmp = mtimecmp_q;

endmodule

// File: rtl/dmem_resp.sv
// Data memory responder: address decode, byte-lane RAM with zero-latency
// loads, CLINT timer and the tohost mailbox.
module dmem_resp
  import dmem_resp_pkg::*;
#(
  parameter int unsigned RAM_AW    = 16,
  parameter int unsigned TIMER_DIV = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  dmem_resp_if.slave      bus,
  output logic            timer_irq_q_o,
  output logic            tohost_v_q_o,
  output logic [XLEN-1:0] tohost_data_q_o
);

  localparam int unsigned WordAw = RAM_AW - 2;

  target_e           tgt;
  logic [1:0]        off;
  logic              hi_sel;
  logic              size_ok, size_w, misaligned;
  logic              fault, acc_ok, wr_en, rd_en;
  logic              ram_we, tohost_we, mtime_we, mtimecmp_we;
  logic [3:0]        lane_mask;
  logic [XLEN-1:0]   lane_data, ram_word, ram_shift, ram_rdata, load_data;
  logic [WordAw-1:0] word_idx;
  logic [63:0]       mtime, mtimecmp;

  logic [XLEN-1:0]   mem [0:(2**WordAw)-1];

  assign off      = bus.adr_i[1:0];
  assign hi_sel   = bus.adr_i[2];
  assign word_idx = bus.adr_i[RAM_AW-1:2];

  always_comb begin
    tgt = TgtNone;
    if (bus.adr_i[XLEN-1:RAM_AW] == '0) begin
      tgt = TgtRam;
    end else if (bus.adr_i == MTIMECMP_LO || bus.adr_i == MTIMECMP_HI) begin
      tgt = TgtMtimecmp;
    end else if (bus.adr_i == MTIME_LO || bus.adr_i == MTIME_HI) begin
      tgt = TgtMtime;
    end else if (bus.adr_i == TOHOST_ADR) begin
      tgt = TgtTohost;
    end
  end

  assign size_ok    = bus.access_size_i inside {SIZE_B, SIZE_H, SIZE_W};
  assign size_w     = (bus.access_size_i == SIZE_W);
  assign misaligned = ((bus.access_size_i == SIZE_H) & off[0]) | (size_w & (off != 2'b00));

  // Misalignment is reported upstream, so it only suppresses the access here.
  assign fault  = bus.adr_v_i & ((tgt == TgtNone) | ~size_ok
                                 | ((tgt != TgtRam) & ~size_w)
                                 | ((tgt == TgtTohost) & ~bus.is_store_i));
  assign acc_ok = bus.adr_v_i & ~fault & ~misaligned;
  assign wr_en  = acc_ok & bus.is_store_i;
  assign rd_en  = acc_ok & ~bus.is_store_i;

  // Gating with reset_n keeps the array untouched by a store caught in reset.
  assign ram_we      = wr_en & (tgt == TgtRam) & reset_n;
  assign mtime_we    = wr_en & (tgt == TgtMtime);
  assign mtimecmp_we = wr_en & (tgt == TgtMtimecmp);
  assign tohost_we   = wr_en & (tgt == TgtTohost);

  assign lane_mask = size_lanes(bus.access_size_i, off);
  assign lane_data = bus.store_data_i << {off, 3'b000};

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int l = 0; l < 4; l++) begin
        if (lane_mask[l]) mem[word_idx][8*l +: 8] <= lane_data[8*l +: 8];
      end
    end
  end

  assign ram_word  = mem[word_idx];
  assign ram_shift = ram_word >> {off, 3'b000};
  assign ram_rdata = ram_shift & size_mask(bus.access_size_i);

  always_comb begin
    load_data = '0;
    if (rd_en) begin
      unique case (tgt)
        TgtRam:      load_data = ram_rdata;
        TgtMtimecmp: load_data = hi_sel ? mtimecmp[63:32] : mtimecmp[31:0];
        TgtMtime:    load_data = hi_sel ? mtime[63:32] : mtime[31:0];
        default:     load_data = '0;
      endcase
    end
  end

  assign bus.load_data_o    = load_data;
  assign bus.access_fault_o = fault;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tohost_v_q_o    <= 1'b0;
      tohost_data_q_o <= '0;
    end else begin
      tohost_v_q_o <= tohost_we;
      if (tohost_we) tohost_data_q_o <= bus.store_data_i;
    end
  end

  dmem_clint #(
    .TIMER_DIV (TIMER_DIV)
  ) u_clint (
    .clk         (clk),
    .reset_n     (reset_n),
    .mtime_we    (mtime_we),
    .mtimecmp_we (mtimecmp_we),
    .hi_sel      (hi_sel),
    .wdata       (bus.store_data_i),
    .mtime       (mtime),
    .mtimecmp    (mtimecmp),
    .timer_irq_q (timer_irq_q_o)
  );

endmodule
